crc_byte_feeder: RTL
====================

Name: crc_byte_feeder

Overview:
Byte-to-bit serializer placed directly upstream of the bit-serial CRC-32 stage in the UART path. It takes frame bytes over a valid/ready handshake and emits one bit per cycle on a valid/last/bit stream, which connects straight to the CRC stage's bit input. It also counts bytes per frame and pulses a frame-done strobe aligned with the CRC result.

Parameters:
DATA_W, 8, bits per input word
CNT_W, 16, width of per-frame byte counter

Ports:
CLK  in  1  clock, all logic on rising edge
RST_N  in  1  synchronous reset, active-low
s_valid  in  1  input byte valid
s_ready  out  1  feeder can accept a byte this cycle
s_data  in  DATA_W  input byte
s_last  in  1  byte is last of frame
o_valid  out  1  bit valid, to the CRC stage's in_valid
o_last  out  1  final bit of frame, to the CRC stage's in_last
o_bit  out  1  serial data bit, to the CRC stage's in_bit
busy  out  1  frame in progress (first byte accepted, last bit not yet sent)
byte_cnt  out  CNT_W  bytes accepted in current frame
frame_done  out  1  one-cycle pulse after final bit of frame

Behaviour:
- Reset: RST_N low at a clock edge -> state IDLE, shift reg 0, bit_cnt 0, last_ff 0, byte_cnt 0, busy 0, frame_done 0. o_valid, o_last and o_bit are 0. s_ready is forced 0 while RST_N is low.
- Reset mid-frame: the partial byte and frame are discarded. No o_last or frame_done is generated. On the next clock after RST_N goes high, s_ready is 1.
- FSM states:
  - IDLE: s_ready = 1. A handshake (s_valid & s_ready) loads the shift reg with s_data, last_ff with s_last, sets bit_cnt = 0 and moves to SHIFT.
  - SHIFT: o_valid = 1 every cycle. o_bit = shift reg [DATA_W-1] (MSB first). On each cycle the shift reg shifts left by 1 and bit_cnt increments.
- Final bit of a byte (bit_cnt == DATA_W-1):
  - s_ready = 1.
  - o_last = last_ff.
  - If a handshake occurs, the next byte loads and SHIFT continues with no bubble.
  - Otherwise the FSM returns to IDLE.
- Throughput: one bit per cycle. Back-to-back bytes give a continuous o_valid. Latency from handshake to the first o_valid is 1 cycle.
- s_ready is derived from registered state only; there is no combinational path from s_valid. o_* outputs are driven from registers only.
- s_valid with s_ready low is ignored; the source must hold the byte. s_data and s_last are sampled only on a handshake.
- byte_cnt:
  - Increments on each handshake and saturates at 2^CNT_W-1.
  - Returns to 0 on the cycle after the final bit of a last byte.
  - If a new frame's first byte is accepted in that same final-bit cycle, byte_cnt becomes 1.
- busy: set on the first handshake of a frame. Cleared after the final bit of the last byte, unless a new byte is accepted in that cycle, in which case it stays 1.
- frame_done: registered o_valid & o_last. It pulses in the same cycle as the CRC stage's out_valid.
- Frame of one byte with s_last = 1: valid. The CRC stage sees 8 bits, with o_last on the 8th.

Optional Feature:
CRC_FEED_LSB_FIRST_EN
- Defined: o_bit = shift reg [0], and the shift reg shifts right each bit (LSB first, UART wire order).
- Undefined: MSB first, as described above.
- Handshake, timing and counters are identical in both cases.

Test Plan:
- Reset then a single byte 0xA5 with s_last=1 -> o_bit 1,0,1,0,0,1,0,1 on 8 consecutive o_valid cycles; o_last only on the 8th; frame_done the next cycle; byte_cnt 1 then 0.
- Back-to-back frame of 0x12, 0x34, 0x56 with s_valid held high -> 24 continuous o_valid cycles with no gap; s_ready high only in IDLE and the three final-bit cycles; o_last on bit 24 only; byte_cnt 3 before clearing.
- Source stalls: 0xFF, then s_valid low for 5 cycles, then 0x00 with s_last=1 -> o_valid drops for 5 cycles after bit 8; busy stays 1 throughout; bit stream is 8x1 then 8x0.
- Reset asserted at bit 4 of byte 0x3C in a non-last frame -> next cycle all outputs 0; no frame_done; a following frame 0x81 with last=1 serializes cleanly with byte_cnt 1.
- Frame end overlapping the next frame's first byte: the last byte's final-bit cycle coincides with a handshake for the new frame -> frame_done pulses; byte_cnt goes to 1 (not 0); busy stays 1.
- With CRC_FEED_LSB_FIRST_EN defined, byte 0xA5 with last=1 -> o_bit 1,0,1,0,0,1,0,1 (palindrome check); byte 0x01 with last=1 -> 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/crc_byte_feeder.sv
// ---------------------------------------------------------------------------
// crc_byte_feeder
//
// Byte-to-bit serializer feeding the bit-serial CRC-32 stage in the UART path.
// Bytes arrive over a valid/ready handshake and leave one bit per cycle on a
// valid/last/bit stream. A per-frame byte counter, a busy flag and a
// frame-done strobe (aligned with the CRC stage's result) are also provided.
//
// Optional feature macro: CRC_FEED_LSB_FIRST_EN
//   defined   -> bits leave LSB first (UART wire order)
//   undefined -> bits leave MSB first
//
// Ports:
//   CLK         clock, all logic on rising edge
//   RST_N       synchronous reset, active-low
//   s_valid     input byte valid
//   s_ready     feeder can accept a byte this cycle
//   s_data      input byte
//   s_last      byte is last of frame
//   o_valid     bit valid       (CRC stage in_valid)
//   o_last      final frame bit (CRC stage in_last)
//   o_bit       serial data bit (CRC stage in_bit)
//   busy        frame in progress
//   byte_cnt    bytes accepted in current frame (saturating)
//   frame_done  one-cycle pulse after the final bit of a frame
// ---------------------------------------------------------------------------
module crc_byte_feeder #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_bit,
    output logic              busy,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic              frame_done
);

    localparam int                BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_cnt;
    logic              last_ff;
    logic              final_bit;
    logic              accept;
    logic              frame_end;
    logic              serial_bit;

    // Bit-order selection: both the tapped bit and the shift direction move
    // together so the handshake timing is unaffected by the order.
`ifdef CRC_FEED_LSB_FIRST_EN
    assign serial_bit = shift_reg[0];
`else
    assign serial_bit = shift_reg[DATA_W-1];
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A handshake on the final bit keeps SHIFT running so
    // back-to-back bytes stream without a bubble.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (final_bit) begin
                    state_next = accept ? SHIFT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode. Everything here comes from registered state; RST_N only
    // gates s_ready so nothing is accepted while the block is held in reset.
    always_comb begin
        final_bit = (state == SHIFT) && (bit_cnt == LAST_BIT);
        s_ready   = RST_N && ((state == IDLE) || final_bit);
        accept    = s_valid && s_ready;
        o_valid   = (state == SHIFT);
        o_last    = final_bit && last_ff;
        o_bit     = (state == SHIFT) && serial_bit;
        frame_end = o_last;
    end

    // Datapath: shift register, bit counter, frame bookkeeping.
    // When a frame ends in the same cycle a new byte is accepted, the new
    // frame starts with a count of one and busy never drops.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            last_ff    <= 1'b0;
            byte_cnt   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (accept) begin
                shift_reg <= s_data;
                last_ff   <= s_last;
                bit_cnt   <= '0;
            end else if (state == SHIFT) begin
`ifdef CRC_FEED_LSB_FIRST_EN
                shift_reg <= shift_reg >> 1;
`else
                shift_reg <= shift_reg << 1;
`endif
                bit_cnt   <= bit_cnt + 1'b1;
            end

            if (frame_end) begin
                byte_cnt <= accept ? CNT_W'(1) : '0;
            end else if (accept && (byte_cnt != CNT_MAX)) begin
                byte_cnt <= byte_cnt + 1'b1;
            end

            if (frame_end) begin
                busy <= accept;
            end else if (accept) begin
                busy <= 1'b1;
            end

            frame_done <= o_valid && o_last;
        end
    end

endmodule
